sliding_histogram: RTL and testbench
====================================

// Module: sliding_histogram
// PURPOSE
//  Sliding-window histogram over the last WINDOW accepted samples; successor to the fixed 4-bit/16-bin
//  frame histogram. Single clock (input CDC FIFO stays upstream). Adds valid/ready input, same-bin
//  add/remove cancellation, soft clear, random-access bin query and a continuously scanned peak bin.
// PARAMETERS
//  DATA_W   4   sample width; BINS = 2**DATA_W (localparam)
//  WINDOW   64  window length in samples, >=2, need not be a power of two
//  CNT_W    $clog2(WINDOW+1) (localparam) width of bin counters and fill count
// PORTS
//  clk        in   1       sole clock, rising edge
//  rst        in   1       asynchronous, active-high reset
//  clear      in   1       sync soft clear: empties window, zeroes all bins, restarts peak scan
//  in_valid   in   1       sample valid
//  in_ready   out  1       block can accept; transfer = in_valid & in_ready
//  in_data    in   DATA_W  sample = bin index
//  q_bin      in   DATA_W  query bin index
//  q_count    out  CNT_W   count of q_bin, registered
//  fill       out  CNT_W   samples currently in window (0..WINDOW)
//  win_full   out  1       fill == WINDOW
//  peak_bin   out  DATA_W  bin with highest count at end of last completed sweep
//  peak_count out  CNT_W   its count
//  peak_vld   out  1       pulses 1 cycle when peak_* update
// BEHAVIOUR
//  Reset (rst=1): all outputs 0, in_ready 0, pointers/counters 0, FSM = INIT. Async assert, sync deassert upstream.
//  FSM INIT -> RUN on first clk with rst low (1 cycle); in_ready=1 only in RUN and while clear=0.
//  Accept: sample written to window RAM at wr_ptr; wr_ptr wraps WINDOW-1 -> 0 (explicit compare, not 2^n).
//   fill<WINDOW: cnt[in_data]+=1, fill+=1. fill==WINDOW: oldest sample popped in same cycle,
//   rd_ptr advances with same wrap, cnt[in_data]+=1 and cnt[oldest]-=1; oldest==in_data -> bin unchanged.
//  Counts reflect an accepted sample on the edge after acceptance; sustains 1 sample/cycle.
//  Oldest sample held in a lookahead register (RAM read of rd_ptr+1 issued one cycle early) so pop
//   needs no stall; back-to-back pops and write/read of same RAM address must return correct data.
//  Counters never exceed WINDOW nor underflow; any violation is a design bug (assertion in bench).
//  clear=1 (RUN): next edge zeroes all cnt, fill, pointers, peak_* and peak scan; sample presented
//   in same cycle is NOT accepted (in_ready=0). clear has priority over accept.
//  Query: q_count <= cnt[q_bin] every cycle (1-cycle latency, value after that edge's pre-update state).
//  Peak scan: index s walks 0..BINS-1, one bin/cycle, continuously in RUN; tracks running max (strict >,
//   so lowest bin wins ties); at s==BINS-1 loads peak_bin/peak_count, pulses peak_vld, restarts at 0.
//   Sweep is not atomic w.r.t. updates: each bin sampled at its scan cycle. All-zero histogram -> peak_bin 0,
//   peak_count 0 (peak_vld still pulses).
//  rst mid-operation: everything returns to reset values immediately; no partial sweep output.
// STRUCTURE
//  Histogram counts in flop array (BINS x CNT_W); window buffer inferred 1-wr/1-rd sync RAM.
//  Shared package hist_pkg: clog2-based width helpers, BINS/CNT_W derivation, FSM state encoding (INIT,RUN).
//  Sub-module: hist_window_buf (circular RAM + wrap pointers + lookahead oldest register, outputs oldest/fill).
// TESTING
//  1 reset -> in_ready 0 then 1 after 1 cycle; fill 0, all q_count 0, peak_vld pulses every BINS cycles.
//  2 WINDOW=64, feed 64 samples of 5 -> fill 64, win_full 1, q_bin=5 gives 64; peak_bin 5, peak_count 64.
//  3 then feed 64 samples of 9 back-to-back -> after each, cnt5+cnt9==64; finally cnt5=0, cnt9=64.
//  4 full window of 3s, push 3 -> cnt3 stays 64 (same-bin cancel), fill 64, rd_ptr advanced.
//  5 WINDOW=5, push 0,1,2,3,4,5,6 -> fill 5, counts bins 2..6 =1, bins 0,1 =0 (non-2^n wrap).
//  6 clear asserted with in_valid=1 data 7 -> sample dropped; all counts 0, fill 0; random burst vs
//    reference model ~10k samples with random in_valid/clear, counts match each cycle.

Source files
------------

// File: rtl/hist_pkg.sv
//------------------------------------------------------------------------------
// Module  : hist_pkg
// Brief   : Shared width helpers and FSM state encoding for the sliding histogram.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package hist_pkg;

   function automatic int bins_of(input int data_w);
      return 1 << data_w;
   endfunction

   function automatic int cnt_w_of(input int window);
      return $clog2(window + 1);
   endfunction

   function automatic int ptr_w_of(input int window);
      return (window > 1) ? $clog2(window) : 1;
   endfunction

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } hist_state_t;

endpackage

`default_nettype wire

// File: rtl/hist_window_buf.sv
//------------------------------------------------------------------------------
// Module  : hist_window_buf
// Brief   : Circular sample buffer with wrap pointers, fill count and a lookahead
//           register that always holds the oldest sample so a pop never stalls.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module hist_window_buf
   import hist_pkg::*;
#(
   parameter  int DATA_W = 4,
   parameter  int WINDOW = 64,
   localparam int CNT_W  = cnt_w_of(WINDOW),
   localparam int PTR_W  = ptr_w_of(WINDOW)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   output logic [DATA_W-1:0] oldest,
   output logic [CNT_W-1:0]  fill,
   output logic              full
);

   localparam logic [PTR_W-1:0] c_last   = PTR_W'(WINDOW - 1);
   localparam logic [CNT_W-1:0] c_window = CNT_W'(WINDOW);

   logic [DATA_W-1:0] r_mem [WINDOW];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_fill;
   logic [DATA_W-1:0] r_oldest;
   logic [PTR_W-1:0]  w_wr_nxt;
   logic [PTR_W-1:0]  w_rd_nxt;
   logic [PTR_W-1:0]  w_rd_addr;
   logic              w_full;
   logic              w_pop;

   assign w_full    = (r_fill == c_window);
   assign w_pop     = push && w_full;
   assign w_wr_nxt  = (r_wr_ptr == c_last) ? '0 : r_wr_ptr + 1'b1;
   assign w_rd_nxt  = (r_rd_ptr == c_last) ? '0 : r_rd_ptr + 1'b1;
   // Read the address that will be oldest after this edge.
   assign w_rd_addr = w_pop ? w_rd_nxt : r_rd_ptr;

   always_ff @(posedge clk) begin
      if (push) begin
         r_mem[r_wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_fill   <= '0;
         r_oldest <= '0;
      end else if (clear) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_fill   <= '0;
      end else begin
         if (push) begin
            r_wr_ptr <= w_wr_nxt;
            if (!w_full) begin
               r_fill <= r_fill + 1'b1;
            end
         end
         if (w_pop) begin
            r_rd_ptr <= w_rd_nxt;
         end
         // Bypass covers a write landing on the address being read (empty buffer).
         r_oldest <= (push && (r_wr_ptr == w_rd_addr)) ? push_data : r_mem[w_rd_addr];
      end
   end

   assign oldest = r_oldest;
   assign fill   = r_fill;
   assign full   = w_full;

endmodule

`default_nettype wire

// File: rtl/sliding_histogram.sv
//------------------------------------------------------------------------------
// Module  : sliding_histogram
// Brief   : Histogram over the last WINDOW accepted samples with bin query and a
//           continuously scanned peak bin.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sliding_histogram
   import hist_pkg::*;
#(
   parameter  int DATA_W = 4,
   parameter  int WINDOW = 64,
   localparam int BINS   = bins_of(DATA_W),
   localparam int CNT_W  = cnt_w_of(WINDOW)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [DATA_W-1:0] q_bin,
   output logic [CNT_W-1:0]  q_count,
   output logic [CNT_W-1:0]  fill,
   output logic              win_full,
   output logic [DATA_W-1:0] peak_bin,
   output logic [CNT_W-1:0]  peak_count,
   output logic              peak_vld
);

   localparam logic [DATA_W-1:0] c_last_bin = DATA_W'(BINS - 1);

   hist_state_t       r_state;
   logic [CNT_W-1:0]  r_cnt [BINS];
   logic [DATA_W-1:0] r_scan;
   logic [DATA_W-1:0] r_run_bin;
   logic [CNT_W-1:0]  r_run_cnt;
   logic              w_accept;
   logic              w_pop;
   logic              w_full;
   logic [DATA_W-1:0] w_oldest;
   logic [CNT_W-1:0]  w_scan_cnt;
   logic              w_take;
   logic [CNT_W-1:0]  w_best_cnt;
   logic [DATA_W-1:0] w_best_bin;

   assign in_ready = (r_state == ST_RUN) && !clear;
   assign w_accept = in_valid && in_ready;
   assign w_pop    = w_accept && w_full;
   assign win_full = w_full;

   hist_window_buf #(
      .DATA_W (DATA_W),
      .WINDOW (WINDOW)
   ) u_buf (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .push      (w_accept),
      .push_data (in_data),
      .oldest    (w_oldest),
      .fill      (fill),
      .full      (w_full)
   );

   // A bin that is both added to and removed from in one cycle stays put.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int b = 0; b < BINS; b++) begin
            r_cnt[b] <= '0;
         end
      end else begin
         for (int b = 0; b < BINS; b++) begin
            if (clear) begin
               r_cnt[b] <= '0;
            end else if (w_accept && (in_data == DATA_W'(b)) &&
                         !(w_pop && (w_oldest == DATA_W'(b)))) begin
               r_cnt[b] <= r_cnt[b] + 1'b1;
            end else if (w_pop && (w_oldest == DATA_W'(b)) &&
                         !(w_accept && (in_data == DATA_W'(b)))) begin
               r_cnt[b] <= r_cnt[b] - 1'b1;
            end
         end
      end
   end

   // Strict compare keeps the lowest bin on ties; bin 0 seeds each sweep.
   assign w_scan_cnt = r_cnt[r_scan];
   assign w_take     = (r_scan == '0) || (w_scan_cnt > r_run_cnt);
   assign w_best_cnt = w_take ? w_scan_cnt : r_run_cnt;
   assign w_best_bin = w_take ? r_scan : r_run_bin;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_INIT;
         r_scan     <= '0;
         r_run_bin  <= '0;
         r_run_cnt  <= '0;
         peak_bin   <= '0;
         peak_count <= '0;
         peak_vld   <= 1'b0;
         q_count    <= '0;
      end else begin
         q_count  <= r_cnt[q_bin];
         peak_vld <= 1'b0;
         case (r_state)
            ST_INIT: begin
               r_state <= ST_RUN;
            end
            ST_RUN: begin
               if (clear) begin
                  r_scan     <= '0;
                  r_run_bin  <= '0;
                  r_run_cnt  <= '0;
                  peak_bin   <= '0;
                  peak_count <= '0;
               end else if (r_scan == c_last_bin) begin
                  r_scan     <= '0;
                  r_run_bin  <= w_best_bin;
                  r_run_cnt  <= w_best_cnt;
                  peak_bin   <= w_best_bin;
                  peak_count <= w_best_cnt;
                  peak_vld   <= 1'b1;
               end else begin
                  r_scan    <= r_scan + 1'b1;
                  r_run_bin <= w_best_bin;
                  r_run_cnt <= w_best_cnt;
               end
            end
            default: begin
               r_state <= ST_INIT;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_sliding_histogram.sv
//------------------------------------------------------------------------------
// Module  : tb_sliding_histogram
// Brief   : Self-checking bench for sliding_histogram at WINDOW=64 and WINDOW=5.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sliding_histogram;

   localparam int DW  = 4;
   localparam int W0  = 64;
   localparam int W1  = 5;
   localparam int CW0 = $clog2(W0 + 1);
   localparam int CW1 = $clog2(W1 + 1);

   typedef struct {
      bit v;
      bit c;
      int d;
      int exp_fill;
      bit exp_full;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   logic [1:0]         clr, vld, rdy, full, pvld;
   logic [1:0][DW-1:0] dat, qb;
   logic [DW-1:0]      pb0, pb1;
   logic [CW0-1:0]     qc0, fill0, pc0;
   logic [CW1-1:0]     qc1, fill1, pc1;

   int n_cmp = 0;
   int n_err = 0;
   int q0[$];
   int q1[$];

   always #5 clk = ~clk;

   sliding_histogram #(.DATA_W(DW), .WINDOW(W0)) u_dut0 (
      .clk(clk), .rst(rst), .clear(clr[0]), .in_valid(vld[0]), .in_ready(rdy[0]),
      .in_data(dat[0]), .q_bin(qb[0]), .q_count(qc0), .fill(fill0), .win_full(full[0]),
      .peak_bin(pb0), .peak_count(pc0), .peak_vld(pvld[0])
   );

   sliding_histogram #(.DATA_W(DW), .WINDOW(W1)) u_dut1 (
      .clk(clk), .rst(rst), .clear(clr[1]), .in_valid(vld[1]), .in_ready(rdy[1]),
      .in_data(dat[1]), .q_bin(qb[1]), .q_count(qc1), .fill(fill1), .win_full(full[1]),
      .peak_bin(pb1), .peak_count(pc1), .peak_vld(pvld[1])
   );

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int get_qc(input int sel);
      return sel ? int'(qc1) : int'(qc0);
   endfunction
   function automatic int get_fill(input int sel);
      return sel ? int'(fill1) : int'(fill0);
   endfunction
   function automatic int get_pb(input int sel);
      return sel ? int'(pb1) : int'(pb0);
   endfunction
   function automatic int get_pc(input int sel);
      return sel ? int'(pc1) : int'(pc0);
   endfunction

   // Reference model: the window is literally the list of retained samples.
   function automatic int mcount(input int sel, input int bin);
      int n = 0;
      if (sel == 0) begin
         foreach (q0[i]) if (q0[i] == bin) n++;
      end else begin
         foreach (q1[i]) if (q1[i] == bin) n++;
      end
      return n;
   endfunction

   function automatic int msize(input int sel);
      return sel ? q1.size() : q0.size();
   endfunction

   task automatic mupdate(input int sel, input bit acc, input bit c, input int d);
      if (sel == 0) begin
         if (c) q0.delete();
         else if (acc) begin
            q0.push_back(d);
            if (q0.size() > W0) void'(q0.pop_front());
         end
      end else begin
         if (c) q1.delete();
         else if (acc) begin
            q1.push_back(d);
            if (q1.size() > W1) void'(q1.pop_front());
         end
      end
   endtask

   // One clock on one DUT (the other idles); called #1 after a rising edge.
   task automatic cyc(input int sel, input bit v, input bit c, input int d, input int qbin);
      int exp_q;
      int win;
      win      = sel ? W1 : W0;
      vld      = '0;
      clr      = '0;
      vld[sel] = v;
      clr[sel] = c;
      dat[sel] = DW'(d);
      qb[sel]  = DW'(qbin);
      #1;
      chk("in_ready", int'(rdy[sel]), int'(!c));
      exp_q = mcount(sel, qbin);
      @(posedge clk);
      #1;
      mupdate(sel, v && !c, c, d);
      chk("fill", get_fill(sel), msize(sel));
      chk("win_full", int'(full[sel]), int'(msize(sel) == win));
      chk("q_count", get_qc(sel), exp_q);
      chk("count bound", int'(get_qc(sel) <= win), 1);
   endtask

   task automatic wait_peak(input int sel, input int n);
      int seen = 0;
      vld = '0;
      clr = '0;
      for (int k = 0; k < 200 && seen < n; k++) begin
         @(posedge clk);
         #1;
         if (pvld[sel]) seen++;
      end
      chk("peak_vld wait", seen, n);
   endtask

   vec_t tv[7];

   initial begin
      rst = 1'b1;
      clr = '0;
      vld = '0;
      dat = '0;
      qb  = '0;
      repeat (3) @(posedge clk);
      #1;
      // 1: reset values, INIT for one cycle, then ready and periodic peak_vld
      chk("rst in_ready", int'(rdy[0]), 0);
      chk("rst fill", get_fill(0), 0);
      chk("rst peak_vld", int'(pvld[0]), 0);
      chk("rst peak_count", get_pc(0), 0);
      rst = 1'b0;
      #1;
      chk("init in_ready", int'(rdy[0]), 0);
      @(posedge clk);
      #1;
      chk("run in_ready", int'(rdy[0]), 1);
      chk("run in_ready w5", int'(rdy[1]), 1);
      for (int b = 0; b < 16; b++) cyc(0, 0, 0, 0, b);
      wait_peak(0, 1);
      for (int k = 1; k <= 32; k++) begin
         @(posedge clk);
         #1;
         chk("peak_vld period", int'(pvld[0]), int'(k % 16 == 0));
      end
      chk("zero peak_bin", get_pb(0), 0);
      chk("zero peak_count", get_pc(0), 0);

      // 2: full window of 5s
      for (int i = 0; i < W0; i++) cyc(0, 1, 0, 5, 5);
      chk("t2 fill", get_fill(0), 64);
      chk("t2 win_full", int'(full[0]), 1);
      cyc(0, 0, 0, 0, 5);
      chk("t2 cnt5", get_qc(0), 64);
      wait_peak(0, 2);
      chk("t2 peak_bin", get_pb(0), 5);
      chk("t2 peak_count", get_pc(0), 64);

      // 3: displace with 9s, sum stays at WINDOW
      for (int i = 0; i < W0; i++) cyc(0, 1, 0, 9, (i % 2) ? 5 : 9);
      cyc(0, 0, 0, 0, 5);
      chk("t3 cnt5", get_qc(0), 0);
      cyc(0, 0, 0, 0, 9);
      chk("t3 cnt9", get_qc(0), 64);

      // 4: same-bin add/remove cancellation, then popping continues correctly
      cyc(0, 0, 1, 0, 0);
      for (int i = 0; i < W0; i++) cyc(0, 1, 0, 3, 3);
      cyc(0, 1, 0, 3, 3);
      cyc(0, 0, 0, 0, 3);
      chk("t4 cnt3", get_qc(0), 64);
      chk("t4 fill", get_fill(0), 64);
      cyc(0, 1, 0, 7, 3);
      cyc(0, 0, 0, 0, 3);
      chk("t4 cnt3 after pop", get_qc(0), 63);
      cyc(0, 0, 0, 0, 7);
      chk("t4 cnt7", get_qc(0), 1);

      // 5: non-power-of-two wrap, table-driven
      for (int i = 0; i < 7; i++) tv[i] = '{1'b1, 1'b0, i, (i < 5) ? i + 1 : 5, (i >= 4)};
      for (int i = 0; i < 7; i++) begin
         cyc(1, tv[i].v, tv[i].c, tv[i].d, 0);
         chk("t5 fill", get_fill(1), tv[i].exp_fill);
         chk("t5 win_full", int'(full[1]), int'(tv[i].exp_full));
      end
      for (int b = 0; b < 16; b++) begin
         cyc(1, 0, 0, 0, b);
         chk("t5 bin", get_qc(1), (b >= 2 && b <= 6) ? 1 : 0);
      end
      wait_peak(1, 2);
      chk("t5 tie peak_bin", get_pb(1), 2);
      chk("t5 tie peak_count", get_pc(1), 1);

      // 6: clear drops the concurrent sample and zeroes everything
      cyc(0, 1, 1, 7, 7);
      chk("t6 fill", get_fill(0), 0);
      chk("t6 peak_count", get_pc(0), 0);
      for (int b = 0; b < 16; b++) begin
         cyc(0, 0, 0, 0, b);
         chk("t6 bin", get_qc(0), 0);
      end

      // Random traffic against the model on both window sizes
      for (int i = 0; i < 10000; i++) begin
         int s, d;
         s = (i < 6000) ? 0 : 1;
         d = ($urandom_range(1, 0) != 0) ? int'($urandom_range(2, 0)) : int'($urandom_range(15, 0));
         cyc(s, ($urandom_range(3, 0) != 0), ($urandom_range(299, 0) == 0), d,
             int'($urandom_range(15, 0)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
